writeback_unit: RTL and testbench
=================================

# writeback_unit

Writeback stage for the five-stage pipeline. Holds the MEM/WB pipeline register and aligns and extends load data. It selects among ALU result, load data and link address, and drives the register-file write port (rw, busW, wrenable, fpoint) consumed by the decode stage. Double-precision FP loads are split into two consecutive register writes under a small FSM, stalling the upstream stages for one cycle.

## Interface
Parameters:
- N, 32, datapath width
- LINK_REG, 31, destination register for jal

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM stage presents an instruction
- in_regwrite  in  1  instruction writes a register
- in_mem2reg  in  1  result comes from memory (else ALU)
- in_jal  in  1  link write of in_linkpc to LINK_REG
- in_rd  in  5  destination register
- in_fpoint  in  2  target file: 00 int, 01 FP single, 10 FP double, 11 no write
- in_dsize  in  2  load size: 00 word, 01 half, 10 byte, 11 word
- in_loadext  in  1  1 = sign-extend sub-word load, 0 = zero-extend
- in_addrlo  in  2  low address bits of the load
- in_alures  in  N  ALU result
- in_memdata  in  N  load data, low/first word
- in_memdata_hi  in  N  second word of a double load
- in_linkpc  in  N  return address for jal
- stall  out  1  upstream must hold its outputs this cycle
- rw  out  5  register-file write address
- busW  out  N  register-file write data
- wrenable  out  1  register-file write strobe
- fpoint  out  2  register-file bank select

## Operation
- Stage register captures all in_* on posedge clk when stall=0. A capture with in_valid=0 loads a bubble (regwrite cleared).
- Data select, highest priority first:
  - jal: busW=in_linkpc, rw=LINK_REG, fpoint=00
  - mem2reg: busW=aligned load data
  - otherwise: busW=alures
- Load align is big-endian.
  - Byte: lane addrlo 0 is bits [31:24] … lane 3 is bits [7:0].
  - Half: addrlo[1]=0 selects [31:16]; 1 selects [15:0]; addrlo[0] is ignored.
  - Word: passthrough.
  - Sub-word results are extended per loadext.
- wrenable=regwrite, forced 0 when fpoint=11, and forced 0 when fpoint=00 with rw=0 (r0 never written). FP register 0 is writable.
- FSM states RUN, HI:
  - RUN, stage holds a valid double write (fpoint=10, regwrite=1): write memdata to rw={rd[4:1],0}, stall=1, next HI.
  - HI: write memdata_hi to rw={rd[4:1],1}, fpoint=10, stall=0, next RUN. The stage register captures new input at the end of HI.
  - RUN, any other instruction: single write, stall=0, stay RUN.
- A double whose mem2reg=0 writes alures to both halves. Its source is an FP-to-FP move.

## Timing
- Latency: one cycle. Inputs captured at edge k; the write is presented during cycle k+1 and committed by the register file at edge k+2.
- rw, busW, wrenable, fpoint, stall are combinational from the stage register and FSM state only, with no in_* to output path.
- Double: two write cycles, one stall cycle, a throughput loss of exactly 1.
- Back-to-back doubles: RUN,HI,RUN,HI with stall pattern 1,0,1,0.
- Reset (asynchronous, any time including mid-double):
  - state=RUN, stage register cleared
  - stall=0, wrenable=0, rw=0, busW=0, fpoint=00
  - the pending high-word write is discarded

## Configuration
- WB_DOUBLE_EN defined: two-cycle double sequence as above.
- Undefined:
  - no HI state; stall tied 0
  - fpoint=10 performs a single write of memdata (or alures) to rw=rd with fpoint=10
  - in_memdata_hi is unused

## Structure
- Package wb_pkg holds:
  - FP_INT=2'b00, FP_SINGLE=2'b01, FP_DOUBLE=2'b10, FP_NONE=2'b11
  - DS_WORD, DS_HALF, DS_BYTE
  - state enum {RUN, HI}
- Sub-module load_align: combinational; inputs memdata, dsize, loadext, addrlo; output the 32-bit aligned value.

## Test plan
- Reset low mid-run: all outputs 0, stall 0. After release, a bubble produces no write.
- Load byte, memdata=0x12F45678, addrlo=1, loadext=1 -> busW=0xFFFFFFF4. Repeat with loadext=0 -> 0x000000F4.
- ALU write to rd=0, fpoint=00 -> wrenable=0. Same with fpoint=01 -> wrenable=1, rw=0.
- jal with in_rd=5, linkpc=0x00400010 -> rw=31, busW=0x00400010, fpoint=00, wrenable=1.
- Double load, rd=7, memdata=0xAAAA0000, hi=0x5555FFFF:
  - cycle 1: rw=6, busW=0xAAAA0000, stall=1
  - cycle 2: rw=7, busW=0x5555FFFF, stall=0
  - the next instruction is written in cycle 3
- Double with rst_n pulsed low during the stall cycle: no write to rw=7 occurs, FSM returns to RUN.

Source files
------------

// File: rtl/wb_pkg.sv
// ============================================================================
// wb_pkg : shared encodings for the writeback stage.
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

   localparam logic [1:0] FP_INT    = 2'b00;
   localparam logic [1:0] FP_SINGLE = 2'b01;
   localparam logic [1:0] FP_DOUBLE = 2'b10;
   localparam logic [1:0] FP_NONE   = 2'b11;

   localparam logic [1:0] DS_WORD = 2'b00;
   localparam logic [1:0] DS_HALF = 2'b01;
   localparam logic [1:0] DS_BYTE = 2'b10;

   typedef enum logic [0:0] {
      RUN = 1'b0,
      HI  = 1'b1
   } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/writeback_unit_if.sv
// ============================================================================
// writeback_unit_if : MEM->WB instruction bundle and register-file write port.
// Rev 1.0
// ============================================================================
`default_nettype none

interface writeback_unit_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_regwrite;
   logic         in_mem2reg;
   logic         in_jal;
   logic [4:0]   in_rd;
   logic [1:0]   in_fpoint;
   logic [1:0]   in_dsize;
   logic         in_loadext;
   logic [1:0]   in_addrlo;
   logic [N-1:0] in_alures;
   logic [N-1:0] in_memdata;
   logic [N-1:0] in_memdata_hi;
   logic [N-1:0] in_linkpc;

   logic         stall;
   logic [4:0]   rw;
   logic [N-1:0] busW;
   logic         wrenable;
   logic [1:0]   fpoint;

   modport master (
      output in_valid, in_regwrite, in_mem2reg, in_jal, in_rd, in_fpoint,
             in_dsize, in_loadext, in_addrlo, in_alures, in_memdata,
             in_memdata_hi, in_linkpc,
      input  stall, rw, busW, wrenable, fpoint
   );

   modport slave (
      input  in_valid, in_regwrite, in_mem2reg, in_jal, in_rd, in_fpoint,
             in_dsize, in_loadext, in_addrlo, in_alures, in_memdata,
             in_memdata_hi, in_linkpc,
      output stall, rw, busW, wrenable, fpoint
   );
endinterface

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// load_align : big-endian sub-word load extraction with sign/zero extension.
// Rev 1.0
// ============================================================================
`default_nettype none

module load_align
   import wb_pkg::*;
(
   input  logic [31:0] memdata,
   input  logic [1:0]  dsize,
   input  logic        loadext,
   input  logic [1:0]  addrlo,
   output logic [31:0] aligned
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = memdata[31:24];
      case (addrlo)
         2'd0:    byte_v = memdata[31:24];
         2'd1:    byte_v = memdata[23:16];
         2'd2:    byte_v = memdata[15:8];
         default: byte_v = memdata[7:0];
      endcase

      // addrlo[0] is deliberately ignored for halfword loads
      half_v = addrlo[1] ? memdata[15:0] : memdata[31:16];

      aligned = memdata;
      case (dsize)
         DS_BYTE: aligned = {{24{loadext & byte_v[7]}}, byte_v};
         DS_HALF: aligned = {{16{loadext & half_v[15]}}, half_v};
         default: aligned = memdata;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// writeback_unit : MEM/WB register, result select and register-file write.
// Macro WB_DOUBLE_EN: FP double loads split into two writes (one stall). Rev 1.0
// ============================================================================
`default_nettype none

module writeback_unit
   import wb_pkg::*;
#(
   parameter int N        = 32,
   parameter int LINK_REG = 31
) (
   input  logic             clk,
   input  logic             rst_n,
   writeback_unit_if.slave  bus
);

   typedef struct packed {
      logic         regwrite;
      logic         mem2reg;
      logic         jal;
      logic [4:0]   rd;
      logic [1:0]   fpoint;
      logic [1:0]   dsize;
      logic         loadext;
      logic [1:0]   addrlo;
      logic [N-1:0] alures;
      logic [N-1:0] memdata;
      logic [N-1:0] linkpc;
   } stage_t;

   stage_t       r_stage;
   logic         w_dbl;
   logic         w_hi;
   logic         w_stall;
   logic [N-1:0] w_memword;
   logic [31:0]  w_aligned;
   logic [4:0]   w_rw;
   logic [1:0]   w_fp;
   logic [N-1:0] w_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage <= '0;
      end else if (!w_stall) begin
         if (bus.in_valid) begin
            r_stage.regwrite <= bus.in_regwrite;
            r_stage.mem2reg  <= bus.in_mem2reg;
            r_stage.jal      <= bus.in_jal;
            r_stage.rd       <= bus.in_rd;
            r_stage.fpoint   <= bus.in_fpoint;
            r_stage.dsize    <= bus.in_dsize;
            r_stage.loadext  <= bus.in_loadext;
            r_stage.addrlo   <= bus.in_addrlo;
            r_stage.alures   <= bus.in_alures;
            r_stage.memdata  <= bus.in_memdata;
            r_stage.linkpc   <= bus.in_linkpc;
         end else begin
            r_stage <= '0;
         end
      end
   end

   // jal outranks the FP bank, so a jal is never treated as a double
   assign w_dbl = r_stage.regwrite && (r_stage.fpoint == FP_DOUBLE) && !r_stage.jal;

`ifdef WB_DOUBLE_EN
   wb_state_e    r_state;
   logic [N-1:0] r_memdata_hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_memdata_hi <= '0;
      end else if (!w_stall) begin
         r_memdata_hi <= bus.in_valid ? bus.in_memdata_hi : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
      end else begin
         case (r_state)
            RUN:     if (w_dbl) r_state <= HI;
            HI:      r_state <= RUN;
            default: r_state <= RUN;
         endcase
      end
   end

   assign w_hi      = (r_state == HI);
   assign w_stall   = (r_state == RUN) && w_dbl;
   assign w_memword = w_hi ? r_memdata_hi : r_stage.memdata;
`else
   assign w_hi      = 1'b0;
   assign w_stall   = 1'b0;
   assign w_memword = r_stage.memdata;
`endif

   load_align u_load_align (
      .memdata (r_stage.memdata[31:0]),
      .dsize   (r_stage.dsize),
      .loadext (r_stage.loadext),
      .addrlo  (r_stage.addrlo),
      .aligned (w_aligned)
   );

   always_comb begin
      w_rw   = r_stage.rd;
      w_fp   = r_stage.fpoint;
      w_data = r_stage.alures;
      if (r_stage.jal) begin
         w_rw   = 5'(LINK_REG);
         w_fp   = FP_INT;
         w_data = r_stage.linkpc;
      end else begin
         // double words bypass sub-word alignment
         if (r_stage.mem2reg) begin
            w_data = (r_stage.fpoint == FP_DOUBLE) ? w_memword : N'(w_aligned);
         end
`ifdef WB_DOUBLE_EN
         if (w_dbl) begin
            w_rw = {r_stage.rd[4:1], w_hi};
         end
`endif
      end
   end

   assign bus.stall    = w_stall;
   assign bus.rw       = w_rw;
   assign bus.busW     = w_data;
   assign bus.fpoint   = w_fp;
   assign bus.wrenable = r_stage.regwrite && (w_fp != FP_NONE) &&
                         !((w_fp == FP_INT) && (w_rw == 5'd0));

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// tb_writeback_unit : randomized scoreboard bench for writeback_unit.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_writeback_unit;

`ifdef WB_DOUBLE_EN
   localparam bit DBL_EN = 1'b1;
`else
   localparam bit DBL_EN = 1'b0;
`endif

   typedef struct {
      bit        valid;
      bit        regwrite;
      bit        mem2reg;
      bit        jal;
      bit [4:0]  rd;
      bit [1:0]  fpoint;
      bit [1:0]  dsize;
      bit        loadext;
      bit [1:0]  addrlo;
      bit [31:0] alures;
      bit [31:0] memdata;
      bit [31:0] memdata_hi;
      bit [31:0] linkpc;
   } instr_t;

   typedef struct {
      bit        care;
      bit        stall;
      bit        we;
      bit [4:0]  rw;
      bit [31:0] busw;
      bit [1:0]  fp;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   exp_t q[$];

   writeback_unit_if #(.N(32)) bus ();

   writeback_unit #(.N(32), .LINK_REG(31)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
      end
   endfunction

   // Reference load extraction: shift the addressed big-endian lane down, then extend.
   function automatic bit [31:0] ref_align(instr_t t);
      bit [31:0] v;
      int        sh;
      if (t.dsize == 2'd2) begin
         sh = (3 - int'(t.addrlo)) * 8;
         v  = (t.memdata >> sh) & 32'hFF;
         if (t.loadext && v[7]) v = v | 32'hFFFF_FF00;
      end else if (t.dsize == 2'd1) begin
         sh = t.addrlo[1] ? 0 : 16;
         v  = (t.memdata >> sh) & 32'hFFFF;
         if (t.loadext && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = t.memdata;
      end
      return v;
   endfunction

   function automatic bit push_expected(instr_t t);
      exp_t      e;
      bit [1:0]  fp;
      bit [4:0]  rw;
      bit [31:0] data;
      bit        dbl;
      e.care = 1'b0; e.stall = 1'b0; e.we = 1'b0; e.rw = '0; e.busw = '0; e.fp = '0;
      if (!t.valid) begin
         q.push_back(e);
         return 1'b0;
      end
      fp   = t.jal ? 2'd0 : t.fpoint;
      rw   = t.jal ? 5'd31 : t.rd;
      if (t.jal)               data = t.linkpc;
      else if (!t.mem2reg)     data = t.alures;
      else if (t.fpoint == 2)  data = t.memdata;
      else                     data = ref_align(t);
      dbl  = DBL_EN && t.regwrite && (t.fpoint == 2'd2) && !t.jal;
      e.care = 1'b1;
      if (dbl) begin
         e.stall = 1'b1; e.we = 1'b1; e.rw = {t.rd[4:1], 1'b0}; e.busw = data; e.fp = 2'd2;
         q.push_back(e);
         e.stall = 1'b0; e.rw = {t.rd[4:1], 1'b1};
         e.busw  = t.mem2reg ? t.memdata_hi : t.alures;
         q.push_back(e);
      end else begin
         e.stall = 1'b0;
         e.we    = t.regwrite && (fp != 2'd3) && !(fp == 2'd0 && rw == 5'd0);
         e.rw    = rw; e.busw = data; e.fp = fp;
         q.push_back(e);
      end
      return dbl;
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      t.valid      = ($urandom_range(0, 9) != 0);
      t.regwrite   = ($urandom_range(0, 7) != 0);
      t.mem2reg    = $urandom_range(0, 1) == 1;
      t.jal        = ($urandom_range(0, 7) == 0);
      t.rd         = 5'($urandom_range(0, 31));
      t.fpoint     = 2'($urandom_range(0, 3));
      t.dsize      = 2'($urandom_range(0, 3));
      t.loadext    = $urandom_range(0, 1) == 1;
      t.addrlo     = 2'($urandom_range(0, 3));
      t.alures     = $urandom;
      t.memdata    = $urandom;
      t.memdata_hi = $urandom;
      t.linkpc     = $urandom;
      return t;
   endfunction

   function automatic instr_t mk(bit regwrite, bit mem2reg, bit jal, bit [4:0] rd,
                                 bit [1:0] fpoint, bit [1:0] dsize, bit loadext,
                                 bit [1:0] addrlo, bit [31:0] alures, bit [31:0] memdata,
                                 bit [31:0] memdata_hi, bit [31:0] linkpc);
      instr_t t;
      t.valid = 1'b1; t.regwrite = regwrite; t.mem2reg = mem2reg; t.jal = jal;
      t.rd = rd; t.fpoint = fpoint; t.dsize = dsize; t.loadext = loadext;
      t.addrlo = addrlo; t.alures = alures; t.memdata = memdata;
      t.memdata_hi = memdata_hi; t.linkpc = linkpc;
      return t;
   endfunction

   task automatic drive(instr_t t);
      bus.in_valid      = t.valid;
      bus.in_regwrite   = t.regwrite;
      bus.in_mem2reg    = t.mem2reg;
      bus.in_jal        = t.jal;
      bus.in_rd         = t.rd;
      bus.in_fpoint     = t.fpoint;
      bus.in_dsize      = t.dsize;
      bus.in_loadext    = t.loadext;
      bus.in_addrlo     = t.addrlo;
      bus.in_alures     = t.alures;
      bus.in_memdata    = t.memdata;
      bus.in_memdata_hi = t.memdata_hi;
      bus.in_linkpc     = t.linkpc;
   endtask

   // During a double's stall cycle random junk is presented; it must not be captured.
   task automatic issue(instr_t t);
      bit dbl;
      @(negedge clk);
      drive(t);
      @(posedge clk);
      #1;
      dbl = push_expected(t);
      if (dbl) begin
         @(negedge clk);
         drive(rand_instr());
         @(posedge clk);
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_stall",    bus.stall,    32'd0);
      chk("rst_wrenable", bus.wrenable, 32'd0);
      chk("rst_rw",       bus.rw,       32'd0);
      chk("rst_busW",     bus.busW,     32'd0);
      chk("rst_fpoint",   bus.fpoint,   32'd0);
   endtask

   task automatic reset_pulse();
      instr_t bubble;
      bit     unused_dbl;
      bubble = rand_instr();
      bubble.valid = 1'b0;
      @(negedge clk);
      #2;
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      q.delete();
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      unused_dbl = push_expected(bubble);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            chk("stall",    bus.stall,    32'(e.stall));
            chk("wrenable", bus.wrenable, 32'(e.we));
            if (e.care) begin
               chk("rw",     bus.rw,     32'(e.rw));
               chk("busW",   bus.busW,   e.busw);
               chk("fpoint", bus.fpoint, 32'(e.fp));
            end
         end
      end
   end

   initial begin : stimulus
      instr_t t;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      t = rand_instr();
      t.valid = 1'b0;
      drive(t);
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      issue(t);
      issue(mk(1, 1, 0, 5'd3,  2'd0, 2'd2, 1, 2'd1, 32'h0, 32'h12F4_5678, 32'h0, 32'h0));
      issue(mk(1, 1, 0, 5'd3,  2'd0, 2'd2, 0, 2'd1, 32'h0, 32'h12F4_5678, 32'h0, 32'h0));
      issue(mk(1, 1, 0, 5'd4,  2'd0, 2'd1, 1, 2'd3, 32'h0, 32'h8001_7FFF, 32'h0, 32'h0));
      issue(mk(1, 1, 0, 5'd4,  2'd0, 2'd1, 1, 2'd0, 32'h0, 32'h8001_7FFF, 32'h0, 32'h0));
      issue(mk(1, 0, 0, 5'd0,  2'd0, 2'd0, 0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0));
      issue(mk(1, 0, 0, 5'd0,  2'd1, 2'd0, 0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0));
      issue(mk(1, 0, 0, 5'd9,  2'd3, 2'd0, 0, 2'd0, 32'h1111_2222, 32'h0, 32'h0, 32'h0));
      issue(mk(1, 0, 1, 5'd5,  2'd0, 2'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0040_0010));
      issue(mk(1, 1, 0, 5'd7,  2'd2, 2'd0, 0, 2'd0, 32'h0, 32'hAAAA_0000, 32'h5555_FFFF, 32'h0));
      issue(mk(1, 0, 0, 5'd12, 2'd0, 2'd0, 0, 2'd0, 32'hCAFE_0001, 32'h0, 32'h0, 32'h0));
      issue(mk(1, 0, 0, 5'd8,  2'd2, 2'd0, 0, 2'd0, 32'h1357_9BDF, 32'h0, 32'h0, 32'h0));
      issue(mk(1, 1, 0, 5'd2,  2'd2, 2'd0, 0, 2'd0, 32'h0, 32'h0101_0101, 32'h0202_0202, 32'h0));
      issue(mk(1, 1, 0, 5'd11, 2'd2, 2'd0, 0, 2'd0, 32'h0, 32'h0303_0303, 32'h0404_0404, 32'h0));

      reset_pulse();
      issue(mk(1, 0, 0, 5'd13, 2'd1, 2'd0, 0, 2'd0, 32'h7777_8888, 32'h0, 32'h0, 32'h0));

      // reset during the stall cycle of a double: the high write must vanish
      @(negedge clk);
      drive(mk(1, 1, 0, 5'd7, 2'd2, 2'd0, 0, 2'd0, 32'h0, 32'hAAAA_0000, 32'h5555_FFFF, 32'h0));
      @(posedge clk);
      #1;
      void'(push_expected(mk(1, 1, 0, 5'd7, 2'd2, 2'd0, 0, 2'd0, 32'h0, 32'hAAAA_0000,
                             32'h5555_FFFF, 32'h0)));
      reset_pulse();
      issue(mk(1, 1, 0, 5'd21, 2'd2, 2'd0, 0, 2'd0, 32'h0, 32'h0BAD_F00D, 32'hFACE_B00C, 32'h0));
      issue(mk(1, 0, 0, 5'd1,  2'd0, 2'd0, 0, 2'd0, 32'h0000_0042, 32'h0, 32'h0, 32'h0));

      for (int i = 0; i < 400; i++) begin
         issue(rand_instr());
      end

      repeat (4) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
